// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU data port
// and a loader/debug port. The CPU has priority. With DMEM_ARB_STARVE_EN
// defined, a starvation guard forces one loader grant after STARVE_MAX
// consecutive denied loader cycles. Without the macro, the CPU has strict
// priority and STARVE_MAX has no effect.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wd            CPU access request
//   cpu_rd, cpu_stall             CPU read data (mem_q), not-serviced flag
//   ld_req/we/addr/wd             loader access request (held until granted)
//   ld_gnt                        loader access performed this cycle
//   ld_rd, ld_rvalid              registered loader read data, 1-cycle valid
//   mem_we/a/d, mem_q             single-port memory interface
module dmem_arbiter #(
  parameter  int unsigned STARVE_MAX = 4,
  localparam int unsigned AW         = 6,
  localparam int unsigned DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wd,
  output logic [DW-1:0] cpu_rd,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wd,
  output logic          ld_gnt,
  output logic [DW-1:0] ld_rd,
  output logic          ld_rvalid,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  input  logic [DW-1:0] mem_q
);

  // Elaboration-time range check on the starvation limit
  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be in 1..15");
  end

  // Registered owner of the previous cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CPU  = 2'd1,
    LDR  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   force_ld;
  logic   ld_rd_pend;

`ifdef DMEM_ARB_STARVE_EN
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] starve_cnt_nxt;

  // Count denied loader cycles; a grant or a withdrawn request restarts it
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!ld_req || ld_gnt) begin
      starve_cnt_nxt = '0;
    end else if (starve_cnt != STARVE_LIM) begin
      starve_cnt_nxt = starve_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Masked by rst so a count left from before reset cannot take the port
  assign force_ld = !rst && ld_req && (starve_cnt == STARVE_LIM);
`else
  assign force_ld = 1'b0;
`endif

  // Grant selection and memory port steering
  always_comb begin
    state_nxt = IDLE;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_d     = '0;
    cpu_stall = 1'b0;
    ld_gnt    = 1'b0;

    if (force_ld) begin
      state_nxt = LDR;
    end else if (cpu_req) begin
      state_nxt = CPU;
    end else if (ld_req) begin
      state_nxt = LDR;
    end

    case (state_nxt)
      CPU: begin
        mem_we = cpu_we;
        mem_a  = cpu_addr;
        mem_d  = cpu_wd;
      end
      LDR: begin
        mem_we    = ld_we;
        mem_a     = ld_addr;
        mem_d     = ld_wd;
        ld_gnt    = 1'b1;
        cpu_stall = cpu_req;
      end
      default: ;
    endcase
  end

  // Owner register and loader read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ld_rd_pend <= 1'b0;
      ld_rd      <= '0;
    end else begin
      state      <= state_nxt;
      ld_rd_pend <= ld_gnt && !ld_we;
      if (ld_gnt && !ld_we) begin
        ld_rd <= mem_q;
      end
    end
  end

  // Valid only in the cycle after a loader-owned read
  assign ld_rvalid = (state == LDR) && ld_rd_pend;

  assign cpu_rd = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter. A driver applies one input vector per cycle
// and queues the expected port values; a monitor on the falling edge pops and
// compares them, and separately checks ld_rd against a queue of expected
// loader read data whenever ld_rvalid is high.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  localparam int unsigned SMAX = 4;

  typedef struct packed {
    logic        rst;
    logic        c_req;
    logic        c_we;
    logic [5:0]  c_a;
    logic [31:0] c_wd;
    logic        l_req;
    logic        l_we;
    logic [5:0]  l_a;
    logic [31:0] l_wd;
  } vin_t;

  typedef struct packed {
    int          tag;
    logic        gnt;
    logic        stall;
    logic        we;
    logic [5:0]  a;
    logic [31:0] d;
    logic        rvalid;
    logic        chk_cpurd;
    logic [31:0] cpurd;
    logic        chk_ldrd;
    logic [31:0] ldrd;
  } exp_t;

  logic        clk       = 1'b0;
  logic        rst       = 1'b1;
  logic        cpu_req   = 1'b0;
  logic        cpu_we    = 1'b0;
  logic [5:0]  cpu_addr  = '0;
  logic [31:0] cpu_wd    = '0;
  logic [31:0] cpu_rd;
  logic        cpu_stall;
  logic        ld_req    = 1'b0;
  logic        ld_we     = 1'b0;
  logic [5:0]  ld_addr   = '0;
  logic [31:0] ld_wd     = '0;
  logic        ld_gnt;
  logic [31:0] ld_rd;
  logic        ld_rvalid;
  logic        mem_we;
  logic [5:0]  mem_a;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  logic [31:0] mem [64] = '{9: 32'h1234_5678, default: 32'h0};

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on rising edge
  always @(posedge clk) begin
    if (mem_we) mem[mem_a] <= mem_d;
  end
  assign mem_q = mem[mem_a];

  dmem_arbiter #(.STARVE_MAX(SMAX)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wd   (cpu_wd),
    .cpu_rd   (cpu_rd),
    .cpu_stall(cpu_stall),
    .ld_req   (ld_req),
    .ld_we    (ld_we),
    .ld_addr  (ld_addr),
    .ld_wd    (ld_wd),
    .ld_gnt   (ld_gnt),
    .ld_rd    (ld_rd),
    .ld_rvalid(ld_rvalid),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %h, expected %h", name, tag, act, expv);
    end
  endtask

  function automatic vin_t vin(input logic r, input logic cr, input logic cw,
                               input logic [5:0] ca, input logic [31:0] cwd,
                               input logic lr, input logic lw,
                               input logic [5:0] la, input logic [31:0] lwd);
    vin_t v;
    v.rst = r;  v.c_req = cr; v.c_we = cw; v.c_a = ca; v.c_wd = cwd;
    v.l_req = lr; v.l_we = lw; v.l_a = la; v.l_wd = lwd;
    return v;
  endfunction

  function automatic exp_t ex(input int tag, input logic g, input logic s,
                              input logic w, input logic [5:0] a,
                              input logic [31:0] d, input logic rv);
    exp_t e;
    e.tag = tag; e.gnt = g; e.stall = s; e.we = w; e.a = a; e.d = d;
    e.rvalid = rv;
    e.chk_cpurd = 1'b0; e.cpurd = '0;
    e.chk_ldrd  = 1'b0; e.ldrd  = '0;
    return e;
  endfunction

  // Apply one vector just after the rising edge and queue its expectations
  task automatic step(input vin_t v, input exp_t e, input logic push_rd,
                      input logic [31:0] rdv);
    @(posedge clk);
    #1;
    rst      = v.rst;
    cpu_req  = v.c_req;
    cpu_we   = v.c_we;
    cpu_addr = v.c_a;
    cpu_wd   = v.c_wd;
    ld_req   = v.l_req;
    ld_we    = v.l_we;
    ld_addr  = v.l_a;
    ld_wd    = v.l_wd;
    exp_q.push_back(e);
    if (push_rd) rd_q.push_back(rdv);
  endtask

  // Monitor: compare port values mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("ld_gnt",    e.tag, 32'(ld_gnt),    32'(e.gnt));
      chk("cpu_stall", e.tag, 32'(cpu_stall), 32'(e.stall));
      chk("mem_we",    e.tag, 32'(mem_we),    32'(e.we));
      chk("mem_a",     e.tag, 32'(mem_a),     32'(e.a));
      chk("mem_d",     e.tag, mem_d,          e.d);
      chk("ld_rvalid", e.tag, 32'(ld_rvalid), 32'(e.rvalid));
      if (e.chk_cpurd) chk("cpu_rd", e.tag, cpu_rd, e.cpurd);
      if (e.chk_ldrd)  chk("ld_rd_hold", e.tag, ld_rd, e.ldrd);
    end
    if (ld_rvalid === 1'b1) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ld_rd: ld_rvalid high with no loader read outstanding");
      end else begin
        chk("ld_rd", -1, ld_rd, rd_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic ldk;
    logic rv;

    // Reset for two cycles, then idle
    step(vin(1, 0,0,0,0, 0,0,0,0), ex(0, 0,0,0,0,0, 0), 0, 0);
    step(vin(1, 0,0,0,0, 0,0,0,0), ex(1, 0,0,0,0,0, 0), 0, 0);
    e = ex(2, 0,0,0,0,0, 0); e.chk_ldrd = 1'b1; e.ldrd = 32'h0;
    step(vin(0, 0,0,0,0, 0,0,0,0), e, 0, 0);

    // CPU write then read back
    step(vin(0, 1,1,6'd5,32'hDEAD_BEEF, 0,0,0,0),
         ex(3, 0,0,1,6'd5,32'hDEAD_BEEF, 0), 0, 0);
    e = ex(4, 0,0,0,6'd5,32'h0, 0); e.chk_cpurd = 1'b1; e.cpurd = 32'hDEAD_BEEF;
    step(vin(0, 1,0,6'd5,32'h0, 0,0,0,0), e, 0, 0);

    // Loader read: granted now, data valid next cycle, then held
    step(vin(0, 0,0,0,0, 1,0,6'd9,32'h0), ex(5, 1,0,0,6'd9,32'h0, 0), 1, 32'h1234_5678);
    step(vin(0, 0,0,0,0, 0,0,0,0), ex(6, 0,0,0,0,0, 1), 0, 0);
    e = ex(7, 0,0,0,0,0, 0); e.chk_ldrd = 1'b1; e.ldrd = 32'h1234_5678;
    step(vin(0, 0,0,0,0, 0,0,0,0), e, 0, 0);

    // Loader write: no rvalid; CPU reads the written word
    step(vin(0, 0,0,0,0, 1,1,6'd20,32'hA5A5_0001),
         ex(8, 1,0,1,6'd20,32'hA5A5_0001, 0), 0, 0);
    step(vin(0, 0,0,0,0, 0,0,0,0), ex(9, 0,0,0,0,0, 0), 0, 0);
    e = ex(10, 0,0,0,6'd20,32'h0, 0); e.chk_cpurd = 1'b1; e.cpurd = 32'hA5A5_0001;
    step(vin(0, 1,0,6'd20,32'h0, 0,0,0,0), e, 0, 0);

    // Simultaneous writes: only the CPU write may reach memory
    step(vin(0, 1,1,6'd33,32'hCAFE_0033, 1,1,6'd34,32'hBAD0_0034),
         ex(11, 0,0,1,6'd33,32'hCAFE_0033, 0), 0, 0);
    e = ex(12, 0,0,0,6'd34,32'h0, 0); e.chk_cpurd = 1'b1; e.cpurd = 32'h0;
    step(vin(0, 1,0,6'd34,32'h0, 0,0,0,0), e, 0, 0);
    e = ex(13, 0,0,0,6'd33,32'h0, 0); e.chk_cpurd = 1'b1; e.cpurd = 32'hCAFE_0033;
    step(vin(0, 1,0,6'd33,32'h0, 0,0,0,0), e, 0, 0);

    // Both requesters held: loader forced every 5th cycle only with the guard
    for (int k = 0; k < 20; k++) begin
      ldk = STARVE && (k % 5 == 4);
      rv  = STARVE && (k > 0) && ((k - 1) % 5 == 4);
      if (ldk) e = ex(100 + k, 1,1,0,6'd9,32'h0, rv);
      else     e = ex(100 + k, 0,0,0,6'd0,32'h0, rv);
      step(vin(0, 1,0,6'd0,32'h0, 1,0,6'd9,32'h0), e, ldk, 32'h1234_5678);
    end
    step(vin(0, 0,0,0,0, 0,0,0,0), ex(120, 0,0,0,0,0, STARVE), 0, 0);

    // Reset during a granted loader read: no rvalid, ld_rd cleared
    step(vin(1, 0,0,0,0, 1,0,6'd9,32'h0), ex(130, 1,0,0,6'd9,32'h0, 0), 0, 0);
    e = ex(131, 0,0,0,0,0, 0); e.chk_ldrd = 1'b1; e.ldrd = 32'h0;
    step(vin(0, 0,0,0,0, 0,0,0,0), e, 0, 0);

    // Reset partway through a starvation count restarts the count
    for (int k = 0; k < 9; k++) begin
      ldk = STARVE && (k == 8);
      if (ldk) e = ex(140 + k, 1,1,0,6'd9,32'h0, 0);
      else     e = ex(140 + k, 0,0,0,6'd0,32'h0, 0);
      step(vin((k == 3), 1,0,6'd0,32'h0, 1,0,6'd9,32'h0), e, ldk, 32'h1234_5678);
    end
    step(vin(0, 0,0,0,0, 0,0,0,0), ex(149, 0,0,0,0,0, STARVE), 0, 0);

    // Loader withdraws mid-count: count restarts from zero
    for (int k = 0; k < 8; k++) begin
      ldk = STARVE && (k == 7);
      if (ldk) e = ex(150 + k, 1,1,0,6'd9,32'h0, 0);
      else     e = ex(150 + k, 0,0,0,6'd0,32'h0, 0);
      step(vin(0, 1,0,6'd0,32'h0, (k != 2),0,6'd9,32'h0), e, ldk, 32'h1234_5678);
    end
    step(vin(0, 0,0,0,0, 0,0,0,0), ex(158, 0,0,0,0,0, STARVE), 0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations and %0d read data left, expected 0 and 0",
               exp_q.size(), rd_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: consecutive denied loader cycles before the loader is forced a grant; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  CPU data-port access request this cycle.
REQ-005 cpu_we  input  1  CPU write enable; qualified by cpu_req.
REQ-006 cpu_addr  input  6  CPU word address.
REQ-007 cpu_wd  input  32  CPU write data.
REQ-008 cpu_rd  output  32  CPU read data, combinational from mem_q.
REQ-009 cpu_stall  output  1  CPU access not serviced this cycle; pipeline holds.
REQ-010 ld_req  input  1  loader/debug port access request; held until granted.
REQ-011 ld_we  input  1  loader write enable; qualified by ld_req.
REQ-012 ld_addr  input  6  loader word address.
REQ-013 ld_wd  input  32  loader write data.
REQ-014 ld_gnt  output  1  loader access performed this cycle.
REQ-015 ld_rd  output  32  registered loader read data.
REQ-016 ld_rvalid  output  1  ld_rd valid; one-cycle pulse.
REQ-017 mem_we  output  1  write enable to the single-port data memory.
REQ-018 mem_a  output  6  memory word address.
REQ-019 mem_d  output  32  memory write data.
REQ-020 mem_q  input  32  memory read data; combinational in mem_a.

Function
REQ-021 FSM states: IDLE (no access), CPU (CPU owns the port), LDR (loader owns the port); the state is the registered owner of the previous cycle and is used only for the starvation logic and status.
REQ-022 Per-cycle grant is combinational: force = (starve_cnt == STARVE_MAX) && ld_req. If force, the loader is granted. Else if cpu_req, the CPU is granted. Else if ld_req, the loader is granted. Else no grant.
REQ-023 When the CPU is granted: mem_a=cpu_addr, mem_d=cpu_wd, mem_we=cpu_we, cpu_stall=0, ld_gnt=0.
REQ-024 When the loader is granted: mem_a=ld_addr, mem_d=ld_wd, mem_we=ld_we, ld_gnt=1, cpu_stall=cpu_req.
REQ-025 When there is no grant: mem_we=0, mem_a=0, mem_d=0, cpu_stall=0, ld_gnt=0.
REQ-026 cpu_rd=mem_q at all times; it is meaningful only when the CPU is granted with cpu_we=0.
REQ-027 A loader read (ld_gnt=1, ld_we=0) captures mem_q into ld_rd at the clock edge; ld_rvalid=1 for exactly the next cycle (latency 1). A loader write yields no ld_rvalid.
REQ-028 ld_rd holds its value until the next loader read.
REQ-029 starve_cnt (4 bits): increments when ld_req=1 and ld_gnt=0, and saturates at STARVE_MAX. It clears when ld_gnt=1 or ld_req=0.
REQ-030 Forced grants do not chain: after a forced grant the counter is 0, so the CPU regains priority in the next cycle.
REQ-031 mem_we is never asserted for more than one requester in a cycle, and never without a grant.
REQ-032 If ld_req falls while the counter is nonzero, the counter clears the next cycle and there is no grant to the loader.

Reset
REQ-033 With rst=1 at the edge: state=IDLE, starve_cnt=0, ld_rd=0, ld_rvalid=0.
REQ-034 During rst=1 the combinational outputs still follow REQ-022..025, but force is inhibited (the counter is 0). A read in flight when reset is applied produces no ld_rvalid after reset.

Configuration
REQ-035 Macro DMEM_ARB_STARVE_EN. When defined, the starvation guard of REQ-022/029 is built.
REQ-036 When DMEM_ARB_STARVE_EN is undefined: strict CPU priority, force is constant 0, no starve_cnt register, and STARVE_MAX is ignored.

Verification
REQ-037 Reset: rst=1 for 2 cycles, then release with no requests -> mem_we=0, ld_gnt=0, cpu_stall=0, ld_rvalid=0, ld_rd=0.
REQ-038 CPU write then read: cpu_req=1, cpu_we=1, cpu_addr=5, cpu_wd=0xDEADBEEF; next cycle cpu_we=0 -> cpu_rd=0xDEADBEEF, cpu_stall=0 throughout.
REQ-039 Loader read latency: memory word 9 = 0x12345678; ld_req=1, ld_we=0, ld_addr=9, cpu_req=0 -> ld_gnt=1 that cycle; next cycle ld_rvalid=1 and ld_rd=0x12345678.
REQ-040 Starvation (guard built, STARVE_MAX=4): cpu_req and ld_req both held high -> CPU is granted in cycles 0-3; in cycle 4 ld_gnt=1 and cpu_stall=1; in cycle 5 the CPU is granted again; the pattern repeats every 5 cycles.
REQ-041 Guard compiled out: same stimulus as REQ-040 for 20 cycles -> ld_gnt stays 0 and cpu_stall stays 0.
REQ-042 Reset mid-read: loader read granted, rst=1 at the next edge -> ld_rvalid=0 and starve_cnt=0 after the edge.
